// File: rtl/iq_boxcar_decimator.sv
// Integrate-and-dump I/Q decimator: averages interleaved real/imag samples over DEC pairs.
// Optional build macro DECIM_ROUND_EN selects round-half-up scaling instead of truncation.
module iq_boxcar_decimator #(
    parameter int DW       = 16,
    parameter int LOG2_DEC = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] data_i,
    input  logic                 valid_i,
    output logic signed [DW-1:0] data_o,
    output logic                 valid_o,
    output logic                 imag_o
);
    localparam int ACC_BITS = DW + LOG2_DEC;

    typedef enum logic {IDLE, EMIT_Q} state_t;

    state_t                      state_q, state_d;
    logic                        chan_q, chan_d;
    logic [LOG2_DEC-1:0]         cnt_q, cnt_d;
    logic signed [ACC_BITS-1:0]  acc_i_q, acc_i_d;
    logic signed [ACC_BITS-1:0]  acc_q_q, acc_q_d;
    logic signed [ACC_BITS-1:0]  hold_q, hold_d;
    logic signed [DW-1:0]        data_q, data_d;
    logic                        valid_q, valid_d;
    logic                        imag_q, imag_d;

    logic signed [ACC_BITS-1:0]  sample_ext;
    logic                        dump;

    function automatic logic signed [DW-1:0] scale(input logic signed [ACC_BITS-1:0] x);
        logic signed [ACC_BITS-1:0] s;
`ifdef DECIM_ROUND_EN
        // Half-LSB bias at full accumulator width; headroom covers DEC/2 extra.
        logic signed [ACC_BITS-1:0] half;
        half = ACC_BITS'(1) << (LOG2_DEC - 1);
        s    = x + half;
`else
        s = x;
`endif
        s = s >>> LOG2_DEC;
        return s[DW-1:0];
    endfunction

    assign sample_ext = {{LOG2_DEC{data_i[DW-1]}}, data_i};
    assign dump       = valid_i && chan_q && (&cnt_q);

    // Datapath: channel toggle, accumulation, dump capture
    always_comb begin
        chan_d  = chan_q;
        cnt_d   = cnt_q;
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        hold_d  = hold_q;
        if (valid_i) begin
            chan_d = ~chan_q;
            if (!chan_q) begin
                acc_i_d = acc_i_q + sample_ext;
            end else if (dump) begin
                hold_d  = acc_q_q + sample_ext;
                acc_i_d = '0;
                acc_q_d = '0;
                cnt_d   = '0;
            end else begin
                acc_q_d = acc_q_q + sample_ext;
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (dump) state_d = EMIT_Q;
            EMIT_Q:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Real result leaves on the dump edge, imag from hold_q one edge later
    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        imag_d  = imag_q;
        if (state_q == EMIT_Q) begin
            data_d  = scale(hold_q);
            valid_d = 1'b1;
            imag_d  = 1'b1;
        end else if (dump) begin
            data_d  = scale(acc_i_q);
            valid_d = 1'b1;
            imag_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            chan_q  <= 1'b0;
            cnt_q   <= '0;
            acc_i_q <= '0;
            acc_q_q <= '0;
            hold_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            imag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            cnt_q   <= cnt_d;
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            imag_q  <= imag_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign imag_o  = imag_q;
endmodule

// File: tb/tb_iq_boxcar_decimator.sv
// Random + directed bench for iq_boxcar_decimator against a sample-buffer averaging model.
module tb_iq_boxcar_decimator;
    localparam int DW  = 16;
    localparam int L2  = 2;
    localparam int DEC = 1 << L2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic signed [DW-1:0] data_i;
    logic                 valid_i;
    logic signed [DW-1:0] data_o;
    logic                 valid_o;
    logic                 imag_o;

    always #5 clk = ~clk;

    iq_boxcar_decimator #(.DW(DW), .LOG2_DEC(L2)) dut (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
        .data_o(data_o), .valid_o(valid_o), .imag_o(imag_o)
    );

    int checks = 0;
    int errors = 0;

    // Model: samples accepted since the last dump/reset, plus the pending imag result
    int smp[$];
    bit pend;
    int pend_val;
    bit exp_v;
    bit exp_im;
    int exp_d;

    function automatic int fdiv(int a, int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int mean(int s);
`ifdef DECIM_ROUND_EN
        return fdiv(s + DEC / 2, DEC);
`else
        return fdiv(s, DEC);
`endif
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input int d, input logic r);
        int si, sq;
        valid_i = v;
        data_i  = DW'(d);
        rst_n   = r;
        @(posedge clk);
        if (!r) begin
            smp.delete();
            pend   = 0;
            exp_v  = 0;
            exp_im = 0;
            exp_d  = 0;
        end else begin
            exp_v = 0;
            if (pend) begin
                exp_v  = 1;
                exp_im = 1;
                exp_d  = pend_val;
                pend   = 0;
            end
            if (v) begin
                smp.push_back(int'($signed(DW'(d))));
                if (smp.size() == 2 * DEC) begin
                    si = 0;
                    sq = 0;
                    for (int k = 0; k < DEC; k++) begin
                        si += smp[2*k];
                        sq += smp[2*k+1];
                    end
                    exp_v    = 1;
                    exp_im   = 0;
                    exp_d    = mean(si);
                    pend     = 1;
                    pend_val = mean(sq);
                    smp.delete();
                end
            end
        end
        @(negedge clk);
        chk("valid_o", int'(valid_o), int'(exp_v));
        if (!r) chk("rst_imag_o", int'(imag_o), 0);
        if (exp_v) begin
            chk("imag_o", int'(imag_o), int'(exp_im));
            chk("data_o", int'(data_o), exp_d);
        end else begin
            chk("data_hold", int'(data_o), exp_d);
        end
    endtask

    task automatic send_pair(input int i, input int q, input int gap);
        step(1'b1, i, 1'b1);
        for (int g = 0; g < gap; g++) step(1'b0, 0, 1'b1);
        step(1'b1, q, 1'b1);
        for (int g = 0; g < gap; g++) step(1'b0, 0, 1'b1);
    endtask

    initial begin
        valid_i = 1'b0;
        data_i  = '0;
        rst_n   = 1'b0;
        step(1'b1, 1234, 1'b0);
        step(1'b0, 0, 1'b0);

        // Constant input, valid every 3rd cycle
        for (int k = 0; k < DEC; k++) send_pair(100, -100, 2);
        for (int k = 0; k < 3; k++) step(1'b0, 0, 1'b1);

        // Rounding corner
        send_pair(1, -1, 0); send_pair(1, -1, 0); send_pair(1, -1, 0); send_pair(0, -1, 0);
        for (int k = 0; k < 3; k++) step(1'b0, 0, 1'b1);

        // Full-scale extremes
        for (int k = 0; k < DEC; k++) send_pair(32767, -32768, 1);
        for (int k = 0; k < 3; k++) step(1'b0, 0, 1'b1);

        // Back-to-back 1..16
        for (int k = 1; k <= 16; k++) step(1'b1, k, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 0, 1'b1);

        // Reset mid-block discards partial sums
        for (int k = 0; k < 3; k++) send_pair(50, 50, 0);
        step(1'b0, 0, 1'b0);
        for (int k = 0; k < DEC; k++) send_pair(10, -10, 0);
        for (int k = 0; k < 3; k++) step(1'b0, 0, 1'b1);

        // Reset landing on the EMIT_Q edge suppresses the imag output
        for (int k = 0; k < DEC; k++) send_pair(7, 9, 0);
        step(1'b1, 55, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 0, 1'b1);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 4000; n++) begin
            logic v;
            logic r;
            v = ($urandom_range(0, 99) < 70);
            r = ($urandom_range(0, 499) != 0);
            step(v, int'($signed(DW'($urandom))), r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
